oversample_phase_ctrl: RTL and testbench

//  Data-recovery controller behind the 4x oversampling front end. Consumes the 8-sample

---
 rtl/oversample_pkg.sv | 25 ++
 rtl/oversample_phase_ctrl_if.sv | 49 ++++
 rtl/oversample_edge_hist.sv | 73 +++++++
 rtl/oversample_phase_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_oversample_phase_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oversample_pkg.sv
// -----------------------------------------------------------------------------
// oversample_pkg
// Shared types and constants for the 4x oversampling data-recovery controller.
//   phase_t          : sampling phase P (samples taken at P and P+4)
//   dru_state_e      : controller state, ACQ (acquiring) or TRACK
//   SAMPLES_PER_CLK  : samples delivered by the front end per clk (2 UI)
//   OVERSAMPLE_RATIO : samples per UI, also the number of phase bins
//   PHASE_RESET      : centre phase used after reset
// Optional feature macro used by the files of this block: OVERSAMPLE_STATS_EN.
// -----------------------------------------------------------------------------
package oversample_pkg;

  localparam int SAMPLES_PER_CLK  = 8;
  localparam int OVERSAMPLE_RATIO = 4;

  typedef logic [1:0] phase_t;

  typedef enum logic {
    ACQ   = 1'b0,
    TRACK = 1'b1
  } dru_state_e;

  localparam phase_t PHASE_RESET = 2'd2;

endpackage

// File: rtl/oversample_phase_ctrl_if.sv
// -----------------------------------------------------------------------------
// oversample_phase_ctrl_if
// Bundles the sample input and recovered-data outputs of oversample_phase_ctrl.
//   enable, sample_window            : from the front end (master drives)
//   data_bits, data_num, data_valid  : recovered bits toward the deserializer
//   phase, locked                    : current sampling phase and lock flag
//   dbg_state                        : controller state for observation
//   slip_inc_cnt, slip_dec_cnt,
//   ambig_cnt                        : only when OVERSAMPLE_STATS_EN is defined
//
// Handshake: data_valid is a pure qualifier with no backpressure. In any cycle
// with data_valid=1 the low data_num bits of data_bits are one recovered group
// ([0] earliest); the consumer must take it that cycle. With data_valid=0 the
// data outputs carry no information.
// -----------------------------------------------------------------------------
interface oversample_phase_ctrl_if;
  import oversample_pkg::*;

  logic                       enable;
  logic [SAMPLES_PER_CLK-1:0] sample_window;
  logic [2:0]                 data_bits;
  logic [1:0]                 data_num;
  logic                       data_valid;
  phase_t                     phase;
  logic                       locked;
  dru_state_e                 dbg_state;
`ifdef OVERSAMPLE_STATS_EN
  logic [15:0]                slip_inc_cnt;
  logic [15:0]                slip_dec_cnt;
  logic [15:0]                ambig_cnt;
`endif

  modport master (
    output enable, sample_window,
    input  data_bits, data_num, data_valid, phase, locked, dbg_state
`ifdef OVERSAMPLE_STATS_EN
    , input slip_inc_cnt, slip_dec_cnt, ambig_cnt
`endif
  );

  modport slave (
    input  enable, sample_window,
    output data_bits, data_num, data_valid, phase, locked, dbg_state
`ifdef OVERSAMPLE_STATS_EN
    , output slip_inc_cnt, slip_dec_cnt, ambig_cnt
`endif
  );

endinterface

// File: rtl/oversample_edge_hist.sv
// -----------------------------------------------------------------------------
// oversample_edge_hist
// Edge detector plus per-phase edge histogram over a window of WIN_LEN
// enabled cycles.
//   clk, aresetn     : clock, synchronous active-low reset
//   enable_i         : 0 freezes every register of this block
//   sample_window_i  : 8 samples of this cycle, [0] earliest
//   hist_o[p]        : saturating edge count of bin p for the current window
//   win_done_o       : high during the first enabled cycle after a full window;
//                      hist_o then holds the complete window, and that cycle's
//                      edges seed the next window instead of being accumulated
// -----------------------------------------------------------------------------
module oversample_edge_hist
  import oversample_pkg::*;
#(
  parameter int WIN_LEN = 256,
  parameter int CNT_W   = 10
) (
  input  logic                                   clk,
  input  logic                                   aresetn,
  input  logic                                   enable_i,
  input  logic [SAMPLES_PER_CLK-1:0]             sample_window_i,
  output logic [OVERSAMPLE_RATIO-1:0][CNT_W-1:0] hist_o,
  output logic                                   win_done_o
);

  localparam int WIN_W = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                                   prev_sample_q;
  logic [WIN_W-1:0]                       win_cnt_q;
  logic                                   win_done_q;
  logic [OVERSAMPLE_RATIO-1:0][CNT_W-1:0] hist_q, hist_d;
  logic [SAMPLES_PER_CLK-1:0]             edge_vec;

  // Bit i flags a transition between sample i-1 and sample i; sample -1 is
  // the last sample of the previous enabled cycle.
  assign edge_vec = sample_window_i ^ {sample_window_i[SAMPLES_PER_CLK-2:0], prev_sample_q};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  always_comb begin
    hist_d = hist_q;
    for (int p = 0; p < OVERSAMPLE_RATIO; p++) begin
      hist_d[p] = sat_add(win_done_q ? '0 : hist_q[p],
                          {1'b0, edge_vec[p]} + {1'b0, edge_vec[p+OVERSAMPLE_RATIO]});
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      prev_sample_q <= 1'b0;
      win_cnt_q     <= '0;
      win_done_q    <= 1'b0;
      hist_q        <= '0;
    end else if (enable_i) begin
      prev_sample_q <= sample_window_i[SAMPLES_PER_CLK-1];
      win_cnt_q     <= win_cnt_q + 1'b1;
      // WIN_LEN is a power of two, so an all-ones count marks the last cycle
      win_done_q    <= &win_cnt_q;
      hist_q        <= hist_d;
    end
  end

  assign hist_o     = hist_q;
  assign win_done_o = win_done_q;

endmodule

// File: rtl/oversample_phase_ctrl.sv
// -----------------------------------------------------------------------------
// oversample_phase_ctrl
// Data-recovery controller behind a 4x oversampling front end. Histograms edge
// positions per window, steers the sampling phase by at most one step per
// window, and emits 1/2/3 recovered bits per cycle so phase wraps absorb drift.
//   clk      : fabric clock
//   aresetn  : synchronous active-low reset
//   bus      : oversample_phase_ctrl_if.slave (enable, sample_window in;
//              data_bits, data_num, data_valid, phase, locked, dbg_state out)
// Optional: define OVERSAMPLE_STATS_EN to add slip_inc_cnt, slip_dec_cnt and
// ambig_cnt event counters on the interface.
// Data latency: sample_window registered at edge k appears on the data outputs
// after edge k+1. A new phase applies from the cycle after the window end.
// -----------------------------------------------------------------------------
module oversample_phase_ctrl
  import oversample_pkg::*;
#(
  parameter int WIN_LEN      = 256,
  parameter int MIN_EDGES    = 8,
  parameter int LOCK_WINDOWS = 4,
  parameter int CNT_W        = 10
) (
  input logic                   clk,
  input logic                   aresetn,
  oversample_phase_ctrl_if.slave bus
);

  localparam int SUM_W  = CNT_W + 2;
  localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [LOCK_W-1:0] LOCK_SAT = LOCK_W'(LOCK_WINDOWS);
  localparam logic [SUM_W-1:0]  MIN_SUM  = SUM_W'(MIN_EDGES);

  // ---------------------------------------------------------------------------
  // Edge histogram
  // ---------------------------------------------------------------------------
  logic [OVERSAMPLE_RATIO-1:0][CNT_W-1:0] hist;
  logic                                   win_done;

  oversample_edge_hist #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) u_edge_hist (
    .clk             (clk),
    .aresetn         (aresetn),
    .enable_i        (bus.enable),
    .sample_window_i (bus.sample_window),
    .hist_o          (hist),
    .win_done_o      (win_done)
  );

  // ---------------------------------------------------------------------------
  // Window decision
  // ---------------------------------------------------------------------------
  dru_state_e        state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  logic [SUM_W-1:0]  hist_sum;
  logic [CNT_W-1:0]  max_cnt;
  phase_t            edge_bin;
  phase_t            held_bin;
  phase_t            delta;
  logic              acted;

  // Edge bin whose target phase equals the current phase; it wins any tie.
  assign held_bin = phase_q + 2'd2;

  always_comb begin
    hist_sum = '0;
    max_cnt  = hist[0];
    edge_bin = '0;
    for (int i = 0; i < OVERSAMPLE_RATIO; i++) begin
      hist_sum = hist_sum + SUM_W'(hist[i]);
    end
    // Strict compare keeps the lowest index among equal maxima
    for (int i = 1; i < OVERSAMPLE_RATIO; i++) begin
      if (hist[i] > max_cnt) begin
        max_cnt  = hist[i];
        edge_bin = phase_t'(i);
      end
    end
    if (hist[held_bin] == max_cnt) edge_bin = held_bin;
  end

  // Target sits half a UI from the edge; delta is target minus current phase
  assign delta = edge_bin + 2'd2 - phase_q;
  assign acted = bus.enable & win_done & (hist_sum >= MIN_SUM);

  // ---------------------------------------------------------------------------
  // Controller FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state_q    <= ACQ;
      phase_q    <= PHASE_RESET;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ACQ:     if (acted) state_d = TRACK;
      TRACK:   state_d = TRACK;
      default: state_d = ACQ;
    endcase
    if (acted) begin
      case (delta)
        2'd0: if (lock_cnt_q != LOCK_SAT) lock_cnt_d = lock_cnt_q + 1'b1;
        2'd1: begin
          phase_d    = phase_q + 2'd1;
          lock_cnt_d = '0;
        end
        2'd3: begin
          phase_d    = phase_q - 2'd1;
          lock_cnt_d = '0;
        end
        // Edge opposite the sampling point: direction unknown, hold phase
        default: lock_cnt_d = '0;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bit recovery pipeline
  // ---------------------------------------------------------------------------
  logic [SAMPLES_PER_CLK-1:0] s1_win_q;
  phase_t                     s1_phase_q;
  logic                       s1_valid_q;
  logic                       s1_wrap_inc_q;
  logic                       s1_wrap_dec_q;
  phase_t                     prev_phase_q;   // phase of the last enabled sample

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      s1_win_q      <= '0;
      s1_phase_q    <= PHASE_RESET;
      s1_valid_q    <= 1'b0;
      s1_wrap_inc_q <= 1'b0;
      s1_wrap_dec_q <= 1'b0;
      prev_phase_q  <= PHASE_RESET;
    end else begin
      s1_valid_q <= bus.enable & (state_q == TRACK);
      if (bus.enable) begin
        s1_win_q      <= bus.sample_window;
        s1_phase_q    <= phase_q;
        s1_wrap_inc_q <= (prev_phase_q == 2'd3) && (phase_q == 2'd0);
        s1_wrap_dec_q <= (prev_phase_q == 2'd0) && (phase_q == 2'd3);
        prev_phase_q  <= phase_q;
      end
    end
  end

  logic [2:0] bits_d, bits_q;
  logic [1:0] num_d, num_q;
  logic       valid_q;

  always_comb begin
    bits_d = '0;
    num_d  = '0;
    if (s1_valid_q) begin
      if (s1_wrap_inc_q) begin
        // Sampling point moved past the end of the cycle: one bit this time
        bits_d = {2'b00, s1_win_q[4]};
        num_d  = 2'd1;
      end else if (s1_wrap_dec_q) begin
        // Sampling point moved back across the cycle start: one extra bit
        bits_d = {s1_win_q[7], s1_win_q[3], s1_win_q[0]};
        num_d  = 2'd3;
      end else begin
        bits_d = {1'b0, s1_win_q[{1'b1, s1_phase_q}], s1_win_q[{1'b0, s1_phase_q}]};
        num_d  = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      bits_q  <= '0;
      num_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      bits_q  <= bits_d;
      num_q   <= num_d;
      valid_q <= s1_valid_q;
    end
  end

  assign bus.data_bits  = bits_q;
  assign bus.data_num   = num_q;
  assign bus.data_valid = valid_q;
  assign bus.phase      = phase_q;
  assign bus.locked     = (lock_cnt_q >= LOCK_SAT);
  assign bus.dbg_state  = state_q;

`ifdef OVERSAMPLE_STATS_EN
  // ---------------------------------------------------------------------------
  // Slip and ambiguity event counters (wrap-around)
  // ---------------------------------------------------------------------------
  logic [15:0] slip_inc_q, slip_dec_q, ambig_q;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      slip_inc_q <= '0;
      slip_dec_q <= '0;
      ambig_q    <= '0;
    end else if (acted) begin
      if (delta == 2'd1 && phase_q == 2'd3) slip_inc_q <= slip_inc_q + 16'd1;
      if (delta == 2'd3 && phase_q == 2'd0) slip_dec_q <= slip_dec_q + 16'd1;
      if (delta == 2'd2)                    ambig_q    <= ambig_q + 16'd1;
    end
  end

  assign bus.slip_inc_cnt = slip_inc_q;
  assign bus.slip_dec_cnt = slip_dec_q;
  assign bus.ambig_cnt    = ambig_q;
`endif

endmodule

// File: tb/tb_oversample_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_oversample_phase_ctrl
// Bench for oversample_phase_ctrl. A behavioural model follows the sample
// stream window by window; every cycle the DUT phase, lock, state and
// recovered data are compared against it. A table of scenarios (reset, run N
// cycles of a two-pattern alternation, check phase/lock/state) covers the
// basic decisions; hand sequences cover phase wraps and reset mid-window;
// a randomized drifting stream closes out. Stats checks compile only with
// OVERSAMPLE_STATS_EN.
// -----------------------------------------------------------------------------
module tb_oversample_phase_ctrl;
  import oversample_pkg::*;

  localparam int WIN_LEN      = 256;
  localparam int MIN_EDGES    = 8;
  localparam int LOCK_WINDOWS = 4;
  localparam int CNT_W        = 10;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  oversample_phase_ctrl_if bus ();

  oversample_phase_ctrl #(
    .WIN_LEN      (WIN_LEN),
    .MIN_EDGES    (MIN_EDGES),
    .LOCK_WINDOWS (LOCK_WINDOWS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected data per sample: {valid, num[1:0], bits[2:0]}
  logic [5:0] exp_q[$];

  // ---------------------------------------------------------------------------
  // Behavioural model: samples grouped into windows of WIN_LEN enabled cycles
  // ---------------------------------------------------------------------------
  int   m_p, m_lock, m_cnt, m_prev_used;
  bit   m_track;
  int   m_hist[4];
  logic m_prev_s7;
  int   m_inc, m_dec, m_amb;

  task automatic model_reset();
    m_p = 2; m_lock = 0; m_cnt = 0; m_prev_used = 2; m_track = 0;
    for (int i = 0; i < 4; i++) m_hist[i] = 0;
    m_prev_s7 = 1'b0;
    m_inc = 0; m_dec = 0; m_amb = 0;
    exp_q.delete();
    exp_q.push_back(6'd0);
  endtask

  task automatic model_decide();
    int sum, maxv, e, t, d;
    sum = 0; maxv = 0;
    for (int i = 0; i < 4; i++) begin
      sum += m_hist[i];
      if (m_hist[i] > maxv) maxv = m_hist[i];
    end
    if (sum < MIN_EDGES) return;
    if (m_hist[(m_p + 2) % 4] == maxv) e = (m_p + 2) % 4;
    else begin
      e = 3;
      for (int i = 3; i >= 0; i--) if (m_hist[i] == maxv) e = i;
    end
    t = (e + 2) % 4;
    d = (t - m_p + 4) % 4;
    m_track = 1;
    case (d)
      0: if (m_lock < LOCK_WINDOWS) m_lock++;
      1: begin if (m_p == 3) m_inc++; m_p = (m_p + 1) % 4; m_lock = 0; end
      3: begin if (m_p == 0) m_dec++; m_p = (m_p + 3) % 4; m_lock = 0; end
      default: begin m_amb++; m_lock = 0; end
    endcase
  endtask

  task automatic model_sample(input logic en, input logic [7:0] w, output logic [5:0] e);
    int p;
    logic prev;
    e = 6'd0;
    if (!en) return;
    p = m_p;
    if (m_prev_used == 3 && p == 0)      e = {m_track, 2'd1, 2'b00, w[4]};
    else if (m_prev_used == 0 && p == 3) e = {m_track, 2'd3, w[7], w[3], w[0]};
    else                                 e = {m_track, 2'd2, 1'b0, w[p+4], w[p]};
    m_prev_used = p;
    if (m_cnt == WIN_LEN) begin
      model_decide();
      m_cnt = 0;
      for (int i = 0; i < 4; i++) m_hist[i] = 0;
    end
    for (int i = 0; i < 8; i++) begin
      prev = (i == 0) ? m_prev_s7 : w[i-1];
      if (prev != w[i] && m_hist[i % 4] < (1 << CNT_W) - 1) m_hist[i % 4]++;
    end
    m_prev_s7 = w[7];
    m_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input logic en, input logic [7:0] w);
    logic [5:0] e_new, e_old;
    logic [2:0] mask;
    bus.enable        = en;
    bus.sample_window = w;
    @(posedge clk);
    model_sample(en, w, e_new);
    #1;
    if (exp_q.size() > 0) begin
      e_old = exp_q.pop_front();
      check("data_valid", bus.data_valid, e_old[5]);
      if (e_old[5]) begin
        mask = (e_old[4:3] == 2'd1) ? 3'b001 : (e_old[4:3] == 2'd2) ? 3'b011 : 3'b111;
        check("data_num", bus.data_num, e_old[4:3]);
        check("data_bits", bus.data_bits & mask, e_old[2:0] & mask);
      end
    end
    exp_q.push_back(e_new);
    check("phase", bus.phase, m_p);
    check("locked", bus.locked, m_lock >= LOCK_WINDOWS);
    check("state", bus.dbg_state == TRACK, m_track);
`ifdef OVERSAMPLE_STATS_EN
    check("slip_inc_cnt", bus.slip_inc_cnt, m_inc);
    check("slip_dec_cnt", bus.slip_dec_cnt, m_dec);
    check("ambig_cnt", bus.ambig_cnt, m_amb);
`endif
  endtask

  task automatic do_reset(input logic en, input logic [7:0] w);
    aresetn           = 1'b0;
    bus.enable        = en;
    bus.sample_window = w;
    @(posedge clk);
    model_reset();
    #1;
    check("rst data_valid", bus.data_valid, 1'b0);
    check("rst data_num", bus.data_num, 2'd0);
    check("rst data_bits", bus.data_bits, 3'd0);
    check("rst phase", bus.phase, 2'd2);
    check("rst locked", bus.locked, 1'b0);
    check("rst state", bus.dbg_state, ACQ);
`ifdef OVERSAMPLE_STATS_EN
    check("rst slip_inc_cnt", bus.slip_inc_cnt, 16'd0);
    check("rst slip_dec_cnt", bus.slip_dec_cnt, 16'd0);
    check("rst ambig_cnt", bus.ambig_cnt, 16'd0);
`endif
    aresetn = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenario table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] pat_a;
    logic [7:0] pat_b;
    int         cycles;
    logic [1:0] exp_phase;
    logic       exp_locked;
    logic       exp_track;
  } vec_t;

  vec_t vecs[8];

  // Random drifting stream: UI boundaries at sample offset o and o+4
  logic gen_prev;
  int   gen_o;

  function automatic logic [7:0] gen_window(input logic b_prev, input logic b1,
                                            input logic b2, input int o);
    logic [7:0] s;
    for (int i = 0; i < 8; i++) s[i] = (i < o) ? b_prev : ((i < o + 4) ? b1 : b2);
    return s;
  endfunction

  initial begin
    int         wrap_seen, lock_seen, drop_ok, hop_seen;
    logic       prev_locked;
    logic [1:0] prev_phase;
    logic [7:0] w;
    logic       b1, b2;
    int         next_drift;

    aresetn           = 1'b0;
    bus.enable        = 1'b0;
    bus.sample_window = '0;

    vecs[0] = '{8'hF0, 8'h0F, 3*WIN_LEN + 1, 2'd2, 1'b0, 1'b1};
    vecs[1] = '{8'hF0, 8'h0F, 4*WIN_LEN + 1, 2'd2, 1'b1, 1'b1};
    vecs[2] = '{8'h78, 8'h78, WIN_LEN,       2'd2, 1'b0, 1'b0};
    vecs[3] = '{8'h78, 8'h78, WIN_LEN + 1,   2'd1, 1'b0, 1'b1};
    vecs[4] = '{8'h78, 8'h78, 2*WIN_LEN + 1, 2'd1, 1'b0, 1'b1};
    vecs[5] = '{8'h1E, 8'h1E, WIN_LEN + 1,   2'd3, 1'b0, 1'b1};
    vecs[6] = '{8'h3C, 8'h3C, WIN_LEN + 1,   2'd2, 1'b0, 1'b1};
    vecs[7] = '{8'h00, 8'h00, 2*WIN_LEN + 1, 2'd2, 1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      do_reset(1'b0, 8'h00);
      for (int c = 0; c < vecs[v].cycles; c++) step(1'b1, (c % 2 == 1) ? vecs[v].pat_b : vecs[v].pat_a);
      check($sformatf("vec%0d phase", v), bus.phase, vecs[v].exp_phase);
      check($sformatf("vec%0d locked", v), bus.locked, vecs[v].exp_locked);
      check($sformatf("vec%0d track", v), bus.dbg_state == TRACK, vecs[v].exp_track);
    end

    // --- Phase 3 -> 0 wrap: exactly one single-bit group ---
    do_reset(1'b0, 8'h00);
    for (int c = 0; c < WIN_LEN + 1; c++) step(1'b1, 8'h1E);
    check("pre-wrap phase", bus.phase, 2'd3);
    for (int c = 0; c < WIN_LEN; c++) step(1'b1, 8'h3C);
    check("inc wrap phase", bus.phase, 2'd0);
    wrap_seen = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 8'h3C);
      if (bus.data_valid && bus.data_num == 2'd1) begin
        wrap_seen++;
        check("inc wrap bit", bus.data_bits[0], 1'b1);
      end
    end
    check("inc wrap count", wrap_seen, 1);
`ifdef OVERSAMPLE_STATS_EN
    check("slip_inc after wrap", bus.slip_inc_cnt, 16'd1);
`endif

    // --- Lock at phase 0, then phase 0 -> 3 wrap with lock drop ---
    lock_seen = 0;
    for (int c = 0; c < 5*WIN_LEN && lock_seen == 0; c++) begin
      step(1'b1, 8'h3C);
      if (bus.locked) lock_seen = 1;
    end
    check("lock before dec wrap", lock_seen, 1);
    prev_locked = bus.locked;
    hop_seen = 0; drop_ok = 0;
    for (int c = 0; c < 2*WIN_LEN && hop_seen == 0; c++) begin
      prev_phase = bus.phase;
      step(1'b1, 8'h1E);
      if (prev_phase == 2'd0 && bus.phase == 2'd3) begin
        hop_seen = 1;
        drop_ok  = (prev_locked == 1'b1 && bus.locked == 1'b0) ? 1 : 0;
      end
      prev_locked = bus.locked;
    end
    check("dec wrap seen", hop_seen, 1);
    check("locked drop on dec wrap", drop_ok, 1);
    wrap_seen = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, 8'h1E);
      if (bus.data_valid && bus.data_num == 2'd3) begin
        wrap_seen++;
        check("dec wrap bits", bus.data_bits, 3'b010);
      end
    end
    check("dec wrap count", wrap_seen, 1);
`ifdef OVERSAMPLE_STATS_EN
    check("slip_dec after wrap", bus.slip_dec_cnt, 16'd1);
`endif

    // --- Reset mid-window while tracking discards the partial window ---
    for (int c = 0; c < 100; c++) step(1'b1, 8'h1E);
    check("track before reset", bus.dbg_state == TRACK, 1'b1);
    do_reset(1'b1, 8'hA5);
    for (int c = 0; c < WIN_LEN; c++) step(1'b1, 8'h78);
    check("post-reset no early decision", bus.phase, 2'd2);
    step(1'b1, 8'h78);
    check("post-reset first decision", bus.phase, 2'd1);

    // --- Randomized drifting stream with enable gaps and noise ---
    do_reset(1'b0, 8'h00);
    gen_prev   = 1'b0;
    gen_o      = 0;
    next_drift = $urandom_range(300, 700);
    for (int c = 0; c < 6000; c++) begin
      if (c == next_drift) begin
        gen_o      = ($urandom_range(0, 1) == 1) ? (gen_o + 1) % 4 : (gen_o + 3) % 4;
        next_drift = c + $urandom_range(300, 700);
      end
      b1 = 1'($urandom_range(0, 1));
      b2 = 1'($urandom_range(0, 1));
      w  = gen_window(gen_prev, b1, b2, gen_o);
      if ($urandom_range(0, 31) == 0) w[$urandom_range(0, 7)] ^= 1'b1;
      gen_prev = b2;
      step(($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0, w);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
